// File: rtl/countdown_round_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// countdown_round_ctrl_pkg
//   Shared definitions for the round countdown controller:
//     - FSM state encodings and the enum type built on them
//     - digit and load widths
//     - bin_to_bcd(): splits a clamped 0..99 seconds value into two BCD digits
// ---------------------------------------------------------------------------
package countdown_round_ctrl_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_PAUSED = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam int BCD_W      = 4;
  localparam int LOAD_W     = 7;
  localparam int NUM_DIGITS = 3;  // tenths, ones, tens

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_RUN    = ST_RUN,
    S_PAUSED = ST_PAUSED,
    S_DONE   = ST_DONE
  } state_t;

  // Caller guarantees v <= 99, so both quotient and remainder fit a BCD digit.
  function automatic logic [2*BCD_W-1:0] bin_to_bcd(input logic [LOAD_W-1:0] v);
    logic [BCD_W-1:0] tens;
    logic [BCD_W-1:0] ones;
    tens = BCD_W'(v / LOAD_W'(10));
    ones = BCD_W'(v % LOAD_W'(10));
    return {tens, ones};
  endfunction

endpackage

// File: rtl/countdown_round_ctrl_if.sv
// ---------------------------------------------------------------------------
// countdown_round_ctrl_if
//   Control/status bundle between round logic and the countdown controller.
//   master : drives tick_100ms, start, pause, clear, load_sec; reads status
//   slave  : the controller; reads controls, drives timer_enable, the three
//            BCD digits (SS.t), running, done and the expired pulse
// ---------------------------------------------------------------------------
interface countdown_round_ctrl_if;
  import countdown_round_ctrl_pkg::*;

  logic              tick_100ms;
  logic              start;
  logic              pause;
  logic              clear;
  logic [LOAD_W-1:0] load_sec;

  logic              timer_enable;
  logic [BCD_W-1:0]  sec_tens;
  logic [BCD_W-1:0]  sec_ones;
  logic [BCD_W-1:0]  tenths;
  logic              running;
  logic              done;
  logic              expired;

  modport master (
    output tick_100ms, start, pause, clear, load_sec,
    input  timer_enable, sec_tens, sec_ones, tenths, running, done, expired
  );

  modport slave (
    input  tick_100ms, start, pause, clear, load_sec,
    output timer_enable, sec_tens, sec_ones, tenths, running, done, expired
  );

endinterface

// File: rtl/countdown_round_ctrl_bcd_down_digit.sv
// ---------------------------------------------------------------------------
// bcd_down_digit
//   One registered BCD digit that counts down with borrow.
//   clk, rst    : clock, synchronous active-high reset (digit -> 0)
//   load        : load load_val this edge (wins over decrement)
//   load_val    : BCD value to load
//   dec_en      : global decrement enable for the chain
//   borrow_in   : lower digit requests a borrow (tie 1 on the lowest digit)
//   borrow_out  : this digit is 0 and must borrow from the next digit up
//   digit       : current BCD value
//   zero        : current value is 0
// ---------------------------------------------------------------------------
module bcd_down_digit
  import countdown_round_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [BCD_W-1:0] load_val,
  input  logic             dec_en,
  input  logic             borrow_in,
  output logic             borrow_out,
  output logic [BCD_W-1:0] digit,
  output logic             zero
);

  logic [BCD_W-1:0] digit_reg;
  logic [BCD_W-1:0] digit_next;

  assign zero       = (digit_reg == '0);
  // Borrow ripples upward only through digits that are already 0.
  assign borrow_out = borrow_in & zero;
  assign digit      = digit_reg;

  always_comb begin
    digit_next = digit_reg;
    if (load) begin
      digit_next = load_val;
    end else if (dec_en && borrow_in) begin
      // 0 wraps to 9; the caller stops decrementing at 00.0 so the top
      // digit never actually wraps.
      digit_next = zero ? BCD_W'(9) : digit_reg - BCD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      digit_reg <= '0;
    end else begin
      digit_reg <= digit_next;
    end
  end

endmodule

// File: rtl/countdown_round_ctrl.sv
// ---------------------------------------------------------------------------
// countdown_round_ctrl
//   Round timer: loads whole seconds, counts down in tenths on each 100 ms
//   tick, shows SS.t as BCD digits and pulses expired when it reaches 00.0.
//   Parameter MAX_SECONDS (1..99) clamps the loaded value.
//   clk, rst : clock, synchronous active-high reset
//   bus      : countdown_round_ctrl_if.slave
//              in : tick_100ms, start, pause (level), clear, load_sec
//              out: timer_enable (drives upstream timer), sec_tens,
//                   sec_ones, tenths, running, done, expired
//   All outputs come straight from registers.
// ---------------------------------------------------------------------------
module countdown_round_ctrl
  import countdown_round_ctrl_pkg::*;
#(
  parameter int MAX_SECONDS = 99
) (
  input  logic                   clk,
  input  logic                   rst,
  countdown_round_ctrl_if.slave  bus
);

  localparam logic [LOAD_W-1:0] MAX_V = LOAD_W'(MAX_SECONDS);

  state_t            state_reg;
  state_t            state_next;
  logic              timer_enable_reg;
  logic              running_reg;
  logic              done_reg;
  logic              expired_reg;
  logic              expired_next;

  logic [LOAD_W-1:0]    load_clamped;
  logic [2*BCD_W-1:0]   load_bcd;

  // Digit chain, index 0 = tenths, 1 = ones, 2 = tens.
  logic                 digit_load;
  logic                 digit_dec;
  logic [BCD_W-1:0]     digit_load_val [NUM_DIGITS];
  logic [BCD_W-1:0]     digit_q        [NUM_DIGITS];
  logic                 zero_q         [NUM_DIGITS];
  logic [NUM_DIGITS:0]  borrow;

  logic                 count_is_zero;
  logic                 last_tick;

  assign load_clamped = (bus.load_sec > MAX_V) ? MAX_V : bus.load_sec;
  assign load_bcd     = bin_to_bcd(load_clamped);

  // The lowest digit always "borrows" when a decrement is enabled; a borrow
  // falling off the top of the chain means every digit is already 0.
  assign borrow[0]     = 1'b1;
  assign count_is_zero = borrow[NUM_DIGITS];

  // The current count is 00.1, so this decrement lands exactly on 00.0.
  assign last_tick = zero_q[2] && zero_q[1] && (digit_q[0] == BCD_W'(1));

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      bcd_down_digit u_digit (
        .clk        (clk),
        .rst        (rst),
        .load       (digit_load),
        .load_val   (digit_load_val[gi]),
        .dec_en     (digit_dec),
        .borrow_in  (borrow[gi]),
        .borrow_out (borrow[gi+1]),
        .digit      (digit_q[gi]),
        .zero       (zero_q[gi])
      );
    end
  endgenerate

  // Next-state and datapath control. Priority: clear > start > pause > tick.
  always_comb begin
    state_next   = state_reg;
    expired_next = 1'b0;
    digit_load   = 1'b0;
    digit_dec    = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      digit_load_val[i] = '0;
    end

    if (bus.clear) begin
      // Loading all-zero digits aborts the count with no expiry pulse.
      state_next = S_IDLE;
      digit_load = 1'b1;
    end else if (bus.start) begin
      // Restart from any state; a tick in the same cycle is dropped.
      digit_load        = 1'b1;
      digit_load_val[1] = load_bcd[BCD_W-1:0];
      digit_load_val[2] = load_bcd[2*BCD_W-1:BCD_W];
      if (load_clamped == '0) begin
        state_next   = S_DONE;
        expired_next = 1'b1;
      end else if (bus.pause) begin
        state_next = S_PAUSED;
      end else begin
        state_next = S_RUN;
      end
    end else begin
      case (state_reg)
        S_RUN: begin
          if (bus.pause) begin
            state_next = S_PAUSED;
          end else if (bus.tick_100ms && !count_is_zero) begin
            digit_dec = 1'b1;
            if (last_tick) begin
              state_next   = S_DONE;
              expired_next = 1'b1;
            end
          end
        end
        S_PAUSED: begin
          if (!bus.pause) begin
            state_next = S_RUN;
          end
        end
        default: begin
          // IDLE and DONE wait for start/clear; ticks are ignored.
        end
      endcase
    end
  end

  // Status outputs are registered from state_next so they line up with the
  // state they describe (timer_enable drops the cycle after pause/clear/expiry).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= S_IDLE;
      timer_enable_reg <= 1'b0;
      running_reg      <= 1'b0;
      done_reg         <= 1'b0;
      expired_reg      <= 1'b0;
    end else begin
      state_reg        <= state_next;
      timer_enable_reg <= (state_next == S_RUN);
      running_reg      <= (state_next == S_RUN) || (state_next == S_PAUSED);
      done_reg         <= (state_next == S_DONE);
      expired_reg      <= expired_next;
    end
  end

  assign bus.timer_enable = timer_enable_reg;
  assign bus.running      = running_reg;
  assign bus.done         = done_reg;
  assign bus.expired      = expired_reg;
  assign bus.tenths       = digit_q[0];
  assign bus.sec_ones     = digit_q[1];
  assign bus.sec_tens     = digit_q[2];

endmodule

// File: tb/tb_countdown_round_ctrl.sv
// ---------------------------------------------------------------------------
// tb_countdown_round_ctrl
//   Directed bench for countdown_round_ctrl. Each step drives one cycle of
//   inputs, pushes the expected outputs from an integer-tenths reference
//   model onto a scoreboard queue, then pops and compares after the edge.
// ---------------------------------------------------------------------------
module tb_countdown_round_ctrl;
  import countdown_round_ctrl_pkg::*;

  localparam int M_IDLE   = 0;
  localparam int M_RUN    = 1;
  localparam int M_PAUSED = 2;
  localparam int M_DONE   = 3;

  typedef struct {
    logic [3:0] tens;
    logic [3:0] ones;
    logic [3:0] tenths;
    logic       te;
    logic       running;
    logic       done;
    logic       expired;
  } exp_t;

  exp_t sb_q[$];

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  countdown_round_ctrl_if bus_if ();

  countdown_round_ctrl #(.MAX_SECONDS(99)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: count held as an integer number of tenths.
  int m_state = M_IDLE;
  int m_count = 0;
  bit m_exp   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model(input bit r, input bit t, input bit s, input bit p, input bit c, input int l);
    int v;
    m_exp = 1'b0;
    if (r) begin
      m_state = M_IDLE;
      m_count = 0;
    end else if (c) begin
      m_state = M_IDLE;
      m_count = 0;
    end else if (s) begin
      v = (l > 99) ? 99 : l;
      m_count = v * 10;
      if (v == 0) begin
        m_state = M_DONE;
        m_exp   = 1'b1;
      end else if (p) begin
        m_state = M_PAUSED;
      end else begin
        m_state = M_RUN;
      end
    end else if (m_state == M_RUN) begin
      if (p) begin
        m_state = M_PAUSED;
      end else if (t && m_count > 0) begin
        m_count--;
        if (m_count == 0) begin
          m_state = M_DONE;
          m_exp   = 1'b1;
        end
      end
    end else if (m_state == M_PAUSED) begin
      if (!p) m_state = M_RUN;
    end
  endtask

  task automatic step(input bit r, input bit t, input bit s, input bit p, input bit c,
                      input int l, input string tag);
    exp_t e;
    @(negedge clk);
    rst               = r;
    bus_if.tick_100ms = t;
    bus_if.start      = s;
    bus_if.pause      = p;
    bus_if.clear      = c;
    bus_if.load_sec   = 7'(l);
    model(r, t, s, p, c, l);
    e.tens    = 4'(m_count / 100);
    e.ones    = 4'((m_count / 10) % 10);
    e.tenths  = 4'(m_count % 10);
    e.te      = (m_state == M_RUN);
    e.running = (m_state == M_RUN) || (m_state == M_PAUSED);
    e.done    = (m_state == M_DONE);
    e.expired = m_exp;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    $display("%-10s r=%0b t=%0b s=%0b p=%0b c=%0b l=%0d -> %0d%0d.%0d te=%0b run=%0b done=%0b exp=%0b",
             tag, r, t, s, p, c, l, bus_if.sec_tens, bus_if.sec_ones, bus_if.tenths,
             bus_if.timer_enable, bus_if.running, bus_if.done, bus_if.expired);
    chk({tag, ".tens"},    bus_if.sec_tens,     e.tens);
    chk({tag, ".ones"},    bus_if.sec_ones,     e.ones);
    chk({tag, ".tenths"},  bus_if.tenths,       e.tenths);
    chk({tag, ".te"},      bus_if.timer_enable, e.te);
    chk({tag, ".running"}, bus_if.running,      e.running);
    chk({tag, ".done"},    bus_if.done,         e.done);
    chk({tag, ".expired"}, bus_if.expired,      e.expired);
    chk({tag, ".bcd"}, (bus_if.sec_tens <= 4'd9) && (bus_if.sec_ones <= 4'd9) && (bus_if.tenths <= 4'd9), 1);
  endtask

  // Digits as a single number SS.t * 10 for compact directed checks.
  function automatic int shown();
    return bus_if.sec_tens * 100 + bus_if.sec_ones * 10 + bus_if.tenths;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.tick_100ms = 1'b0;
    bus_if.start      = 1'b0;
    bus_if.pause      = 1'b0;
    bus_if.clear      = 1'b0;
    bus_if.load_sec   = '0;

    // Reset and idle ticks
    step(1, 0, 0, 0, 0, 0, "reset");
    step(1, 1, 0, 0, 0, 0, "reset");
    step(0, 1, 0, 0, 0, 0, "idle_tick");
    chk("idle.count", shown(), 0);

    // 1: load 3, 30 ticks with occasional gaps
    step(0, 0, 1, 0, 0, 3, "t1.start");
    chk("t1.loaded", shown(), 30);
    for (int i = 0; i < 30; i++) begin
      step(0, 1, 0, 0, 0, 0, "t1.tick");
      if (i % 7 == 3) step(0, 0, 0, 0, 0, 0, "t1.gap");
    end
    chk("t1.expired", bus_if.expired, 1);
    chk("t1.te_off", bus_if.timer_enable, 0);
    step(0, 1, 0, 0, 0, 0, "t1.done");
    chk("t1.exp_once", bus_if.expired, 0);
    chk("t1.done_lvl", bus_if.done, 1);

    // 2: two-level borrow 10.0 -> 09.9 ... 09.0
    step(0, 0, 1, 0, 0, 10, "t2.start");
    step(0, 1, 0, 0, 0, 0, "t2.tick");
    chk("t2.borrow", shown(), 99);
    for (int i = 0; i < 9; i++) step(0, 1, 0, 0, 0, 0, "t2.tick");
    chk("t2.nine", shown(), 90);

    // 3: pause holds the count and the timer enable
    step(0, 0, 1, 0, 0, 5, "t3.start");
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 0, "t3.tick");
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 0, 1, 0, 0, "t3.pause");
      chk("t3.hold", shown(), 46);
      chk("t3.te_low", bus_if.timer_enable, 0);
    end
    step(0, 0, 0, 0, 0, 0, "t3.resume");
    chk("t3.te_back", bus_if.timer_enable, 1);
    step(0, 1, 0, 0, 0, 0, "t3.tick");
    chk("t3.after", shown(), 45);

    // 4: clamp and zero load
    step(0, 0, 1, 0, 0, 120, "t4.clamp");
    chk("t4.clamp", shown(), 990);
    step(0, 1, 0, 0, 0, 0, "t4.tick");
    step(0, 0, 1, 1, 0, 99, "t4.startp");
    step(0, 1, 0, 1, 0, 0, "t4.ptick");
    step(0, 0, 1, 0, 0, 0, "t4.zero");
    chk("t4.zero_exp", bus_if.expired, 1);
    step(0, 0, 0, 0, 0, 0, "t4.after");
    chk("t4.zero_done", bus_if.done, 1);

    // 5: clear/start collide with ticks
    step(0, 0, 1, 0, 0, 3, "t5.reload");
    step(0, 1, 0, 0, 0, 0, "t5.tick");
    step(0, 1, 0, 0, 0, 0, "t5.tick");
    step(0, 1, 0, 0, 1, 0, "t5.clear");
    chk("t5.clr_exp", bus_if.expired, 0);
    step(0, 1, 1, 0, 0, 7, "t5.st_tick");
    chk("t5.st_tick", shown(), 70);
    step(0, 1, 0, 0, 0, 0, "t5.tick");
    step(0, 1, 1, 0, 0, 2, "t5.restart");
    chk("t5.restart", shown(), 20);
    for (int i = 0; i < 19; i++) step(0, 1, 0, 0, 0, 0, "t5.tick");
    step(0, 1, 0, 0, 1, 0, "t5.clr01");
    chk("t5.clr01_exp", bus_if.expired, 0);
    step(0, 0, 1, 0, 0, 1, "t5.start1");
    for (int i = 0; i < 9; i++) step(0, 1, 0, 0, 0, 0, "t5.tick");
    step(0, 1, 0, 1, 0, 0, "t5.pause01");
    chk("t5.pause01", shown(), 1);
    step(0, 1, 0, 0, 0, 0, "t5.resume");
    step(0, 1, 0, 0, 0, 0, "t5.last");
    chk("t5.last_exp", bus_if.expired, 1);

    // 6: synchronous reset mid-count
    step(0, 0, 1, 0, 0, 4, "t6.start");
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0, 0, "t6.tick");
    step(1, 1, 0, 0, 0, 0, "t6.rst");
    chk("t6.rst_cnt", shown(), 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0, "t6.idle");
    chk("t6.idle_run", bus_if.running, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
